rtc_bus_sequencer: RTL and testbench



---
 rtl/rtc_bus_sequencer_pkg.sv | 36 +++
 rtl/rtc_bus_sequencer_phase_timer.sv | 27 ++
 rtl/rtc_bus_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared definitions for the RTC bus sequencer: FSM states, default phase
// timing and the RTC register map.
package rtc_bus_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_PULSE,
    ST_A_HOLD,
    ST_GAP,
    ST_D_SETUP,
    ST_D_PULSE,
    ST_D_HOLD,
    ST_DONE
  } state_t;

  localparam int T_SETUP_DEF = 1;
  localparam int T_PULSE_DEF = 2;
  localparam int T_HOLD_DEF  = 1;

  localparam logic [7:0] RTC_REG_SECONDS  = 8'h00;
  localparam logic [7:0] RTC_REG_MINUTES  = 8'h02;
  localparam logic [7:0] RTC_REG_HOURS    = 8'h04;
  localparam logic [7:0] RTC_REG_DAY      = 8'h06;
  localparam logic [7:0] RTC_REG_DATE     = 8'h07;
  localparam logic [7:0] RTC_REG_MONTH    = 8'h08;
  localparam logic [7:0] RTC_REG_YEAR     = 8'h09;
  localparam logic [7:0] RTC_REG_COMMAND  = 8'h0B;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Loadable down-counter used to time setup/strobe/hold; zero marks the
// final cycle of the current phase.
module rtc_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Two-phase (address, then data) transaction sequencer for the RTC muxed bus.
// Optional RTC_ADDR_CACHE_EN skips the address phase when the address repeats.
module rtc_bus_sequencer
  import rtc_bus_sequencer_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rtc_cs_n,
  output logic       rtc_ad,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int CNT_W = $clog2(max3(T_SETUP, T_PULSE, T_HOLD)) + 1;
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

  state_t           state;
  state_t           next_state;
  logic             wr_lat;
  logic [7:0]       addr_lat;
  logic [7:0]       wdata_lat;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;
  logic             cache_hit;
  logic             txn_wr;
  logic [7:0]       txn_addr;
  logic [7:0]       txn_wdata;
  logic             nxt_addr_phase;
  logic             nxt_data_phase;

  rtc_phase_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

`ifdef RTC_ADDR_CACHE_EN
  logic [7:0] last_addr;
  logic       cache_valid;

  assign cache_hit = cache_valid && (addr == last_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_addr   <= '0;
      cache_valid <= 1'b0;
    end else if (state == ST_A_HOLD && tmr_zero) begin
      last_addr   <= addr_lat;
      cache_valid <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Outputs are registered from next_state, so the accepting edge must use
  // the live request fields rather than the not-yet-latched copies.
  always_comb begin
    txn_wr    = (state == ST_IDLE) ? wr    : wr_lat;
    txn_addr  = (state == ST_IDLE) ? addr  : addr_lat;
    txn_wdata = (state == ST_IDLE) ? wdata : wdata_lat;
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    unique case (state)
      ST_IDLE: if (req) begin
        next_state = cache_hit ? ST_D_SETUP : ST_A_SETUP;
        tmr_load   = 1'b1;
        tmr_value  = LD_SETUP;
      end
      ST_A_SETUP: if (tmr_zero) begin
        next_state = ST_A_PULSE;
        tmr_load   = 1'b1;
        tmr_value  = LD_PULSE;
      end
      ST_A_PULSE: if (tmr_zero) begin
        next_state = ST_A_HOLD;
        tmr_load   = 1'b1;
        tmr_value  = LD_HOLD;
      end
      ST_A_HOLD: if (tmr_zero) next_state = ST_GAP;
      ST_GAP: begin
        next_state = ST_D_SETUP;
        tmr_load   = 1'b1;
        tmr_value  = LD_SETUP;
      end
      ST_D_SETUP: if (tmr_zero) begin
        next_state = ST_D_PULSE;
        tmr_load   = 1'b1;
        tmr_value  = LD_PULSE;
      end
      ST_D_PULSE: if (tmr_zero) begin
        next_state = ST_D_HOLD;
        tmr_load   = 1'b1;
        tmr_value  = LD_HOLD;
      end
      ST_D_HOLD: if (tmr_zero) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign nxt_addr_phase = (next_state == ST_A_SETUP) || (next_state == ST_A_PULSE) ||
                          (next_state == ST_A_HOLD);
  assign nxt_data_phase = (next_state == ST_D_SETUP) || (next_state == ST_D_PULSE) ||
                          (next_state == ST_D_HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      rtc_cs_n  <= 1'b1;
      rtc_ad    <= 1'b1;
      rtc_rd_n  <= 1'b1;
      rtc_wr_n  <= 1'b1;
      ad_out    <= '0;
      ad_oe     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && req) begin
        wr_lat    <= wr;
        addr_lat  <= addr;
        wdata_lat <= wdata;
      end
      if (state == ST_D_PULSE && tmr_zero && !wr_lat) begin
        rdata <= ad_in;
      end
      busy     <= (next_state != ST_IDLE);
      done     <= (next_state == ST_DONE);
      rtc_cs_n <= !(nxt_addr_phase || nxt_data_phase);
      rtc_ad   <= !nxt_addr_phase;
      rtc_wr_n <= !((next_state == ST_A_PULSE) || (next_state == ST_D_PULSE && txn_wr));
      rtc_rd_n <= !(next_state == ST_D_PULSE && !txn_wr);
      ad_oe    <= nxt_addr_phase || (nxt_data_phase && txn_wr);
      if (nxt_addr_phase) begin
        ad_out <= txn_addr;
      end else if (nxt_data_phase && txn_wr) begin
        ad_out <= txn_wdata;
      end else begin
        ad_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Randomized scoreboard bench for rtc_bus_sequencer; the reference model is
// compiled with or without RTC_ADDR_CACHE_EN to match the DUT build.
module tb_rtc_bus_sequencer;

  localparam int TS  = 1;
  localparam int TP  = 2;
  localparam int TH  = 1;
  localparam int SUM = TS + TP + TH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] ad_in = '0;
  logic       busy, done, rtc_cs_n, rtc_ad, rtc_rd_n, rtc_wr_n, ad_oe;
  logic [7:0] rdata, ad_out;

  rtc_bus_sequencer #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .rtc_cs_n(rtc_cs_n), .rtc_ad(rtc_ad),
    .rtc_rd_n(rtc_rd_n), .rtc_wr_n(rtc_wr_n), .ad_out(ad_out), .ad_oe(ad_oe),
    .ad_in(ad_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    bit         skip;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] cur_rd_val = '0;
  logic [7:0] model_rdata = '0;
  logic [7:0] c_addr = '0;
  bit         c_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The RTC answers reads with a value that steps each strobe cycle, so the
  // capture must come from the last strobe cycle.
  initial begin
    int rd_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rtc_rd_n) begin
        ad_in = cur_rd_val + 8'(rd_idx);
        rd_idx++;
      end else begin
        rd_idx = 0;
        ad_in = 8'($urandom);
      end
    end
  end

  bit   in_txn = 1'b0;
  bit   hold_chk = 1'b0;
  int   cyc, a_str, d_str, bad, bus_bad, gap, a_cyc;
  exp_t e, hold_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn   = 1'b0;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("rdata_hold", int'(rdata), int'(hold_e.rdata));
        chk("busy_after_done", int'(busy), 0);
        hold_chk = 1'b0;
      end
      if (busy && !in_txn) begin
        in_txn = 1'b1;
        cyc = 0; a_str = 0; d_str = 0; bad = 0; bus_bad = 0; gap = 0; a_cyc = 0;
      end
      if (in_txn) begin
        if (q.size() > 0) e = q[0];
        else e = '{default: 0};
        cyc++;
        if (!rtc_wr_n && !rtc_rd_n) bad++;
        if (!rtc_wr_n) begin
          if (!rtc_ad) begin
            a_str++;
            if (ad_out !== e.addr) bus_bad++;
          end else if (e.wr) begin
            d_str++;
            if (ad_out !== e.wdata) bus_bad++;
          end else bad++;
        end
        if (!rtc_rd_n) begin
          if (rtc_ad && !e.wr) d_str++;
          else bad++;
        end
        if (ad_oe && !rtc_rd_n) bad++;
        if (rtc_cs_n && (!rtc_wr_n || !rtc_rd_n || ad_oe)) bad++;
        if (ad_oe && rtc_ad && !e.wr) bad++;
        if (ad_oe && !rtc_ad && ad_out !== e.addr) bus_bad++;
        if (!rtc_cs_n && !rtc_ad) a_cyc++;
        if (rtc_cs_n && !done) gap++;
        if (done) begin
          if (q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            void'(q.pop_front());
            $display("txn %s addr=0x%02h skip=%0d latency=%0d rdata=0x%02h",
                     e.wr ? "WR" : "RD", e.addr, e.skip, cyc, rdata);
            chk("latency", cyc, e.lat);
            chk("addr_strobes", a_str, e.skip ? 0 : TP);
            chk("data_strobes", d_str, TP);
            chk("illegal_pins", bad, 0);
            chk("bus_value", bus_bad, 0);
            chk("addr_cycles", a_cyc, e.skip ? 0 : SUM);
            chk("gap_cycles", gap, e.skip ? 0 : 1);
            chk("rdata", int'(rdata), int'(e.rdata));
            hold_e   = e;
            hold_chk = 1'b1;
          end
          in_txn = 1'b0;
        end
      end else if (done) begin
        chk("done_while_idle", 1, 0);
      end
    end
  end

  task automatic do_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] rv, input bit guard);
    exp_t x;
    bit   got;
    x.wr = w;
    x.addr = a;
    x.wdata = d;
`ifdef RTC_ADDR_CACHE_EN
    x.skip = c_valid && (c_addr == a);
`else
    x.skip = 1'b0;
`endif
    x.lat = x.skip ? SUM + 1 : 2 * SUM + 2;
    if (!w) model_rdata = rv + 8'(TP - 1);
    x.rdata = model_rdata;
    c_valid = 1'b1;
    c_addr  = a;
    q.push_back(x);
    cur_rd_val = rv;
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; wr = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    if (guard) begin
      repeat (2) @(posedge clk);
      #1;
      req = 1'b1; wr = 1'b1; addr = 8'h22; wdata = 8'h22;
      @(posedge clk);
      #1;
      req = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dcnt;
    bit got;
    // Reset held with a pending request: nothing may start.
    req = 1'b1; wr = 1'b1; addr = 8'h21; wdata = 8'h45;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rdata", int'(rdata), 0);
      chk("rst_pins", int'({rtc_cs_n, rtc_ad, rtc_rd_n, rtc_wr_n, ad_oe}), 5'b11110);
      chk("rst_ad_out", int'(ad_out), 0);
    end
    req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_txn(1'b1, 8'h21, 8'h45, 8'h00, 1'b0);
    do_txn(1'b0, 8'h41, 8'h00, 8'h39, 1'b0);
    do_txn(1'b0, 8'h41, 8'h00, 8'h5C, 1'b0);
    do_txn(1'b0, 8'h42, 8'h00, 8'hA0, 1'b0);
    do_txn(1'b1, 8'h10, 8'h77, 8'h00, 1'b1);
    for (int n = 0; n < 16; n++) begin
      do_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 8'($urandom),
             8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Abort a write in its data strobe with reset.
    req = 1'b1; wr = 1'b1; addr = 8'h30; wdata = 8'h55;
    @(posedge clk);
    #1;
    req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!rtc_wr_n && rtc_ad) begin
        got = 1'b1;
        break;
      end
    end
    chk("reach_d_pulse", int'(got), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_pins", int'({rtc_cs_n, rtc_rd_n, rtc_wr_n, ad_oe}), 4'b1110);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    model_rdata = '0;
    c_valid = 1'b0;
    rst_n = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("no_done_after_abort", dcnt, 0);

    do_txn(1'b0, 8'h41, 8'h00, 8'h66, 1'b0);
    do_txn(1'b0, 8'h41, 8'h00, 8'h13, 1'b0);
    do_txn(1'b1, 8'h41, 8'hC3, 8'h00, 1'b0);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
